// File: rtl/lcd_pkg.sv
// Shared types and default timing for the HD44780-style LCD bus bridge.
// No logic here, so there is no latency.
// No flow control here; the constants only size the bridge's timers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_RECOVER
  } lcd_state_t;

  // Defaults sized for a 50 MHz clock.
  localparam int DEF_SETUP_CYCLES   = 3;
  localparam int DEF_PULSE_CYCLES   = 12;
  localparam int DEF_HOLD_CYCLES    = 2;
  localparam int DEF_RECOVER_CYCLES = 8;
  localparam int DEF_POLL_LIMIT     = 4096;

  // Busy flag position on the panel data bus.
  localparam int BF_BIT = 7;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Phase timer: counts a loaded zero-based value down and flags the last cycle.
// done is high in the load_val+1'th cycle after load; load has priority.
// No backpressure; the owner reloads it at every phase change.
module lcd_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;
  logic         active;

  // Down-count from the loaded value and go quiet after the final cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= load_val;
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

  assign done = active && (cnt == '0);

endmodule

// File: rtl/lcd_bus_bridge.sv
// Turns single-beat register requests into timed LCD bus cycles and polls BF after writes.
// Accept to E rise is SETUP_CYCLES+1 clocks; a bare write frees the port after 1+S+P+H+R clocks.
// reqReady is high only in IDLE; requests seen elsewhere are ignored until reqReady returns.
module lcd_bus_bridge
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES,
  parameter int POLL_BUSY      = 1,
  parameter int POLL_LIMIT     = DEF_POLL_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reqValid,
  output logic       reqReady,
  input  logic       reqRS,
  input  logic       reqRW,
  input  logic [7:0] reqData,
  output logic       rspValid,
  output logic [7:0] rspData,
  output logic       busy,
  output logic       timeout,
  output logic       lcdRS,
  output logic       lcdRW,
  output logic       lcdE,
  output logic [7:0] lcdDataOut,
  output logic       lcdDataOe,
  input  logic [7:0] lcdDataIn
);

  localparam int TW = $clog2(max4(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES, RECOVER_CYCLES) + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);

  lcd_state_t    state;
  logic          start;     // one-clock gap between acceptance and the first SETUP cycle
  logic          polling;   // current bus cycle is an internal BF read
  logic          is_write;  // the user request of this transaction was a write
  logic          bf;        // busy flag captured by the latest poll
  logic [PW-1:0] poll_cnt;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  lcd_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Reload the timer with the length of whichever phase starts on the next edge.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: if (start) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(SETUP_CYCLES - 1);
      end
      ST_SETUP: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(PULSE_CYCLES - 1);
      end
      ST_PULSE: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(HOLD_CYCLES - 1);
      end
      ST_HOLD: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(RECOVER_CYCLES - 1);
      end
      // Harmless when returning to IDLE; needed when a poll cycle follows.
      ST_RECOVER: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(SETUP_CYCLES - 1);
      end
      default: ;
    endcase
  end

  // Bus-cycle sequencer; every pin and status output is a register of this block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      start      <= 1'b0;
      polling    <= 1'b0;
      is_write   <= 1'b0;
      bf         <= 1'b0;
      poll_cnt   <= '0;
      reqReady   <= 1'b0;
      rspValid   <= 1'b0;
      rspData    <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      lcdE       <= 1'b0;
      lcdRS      <= 1'b0;
      lcdRW      <= 1'b1;
      lcdDataOut <= '0;
      lcdDataOe  <= 1'b0;
    end else begin
      rspValid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            start     <= 1'b0;
            state     <= ST_SETUP;
            lcdDataOe <= !lcdRW;
          end else if (reqValid && reqReady) begin
            start      <= 1'b1;
            reqReady   <= 1'b0;
            busy       <= 1'b1;
            lcdRS      <= reqRS;
            lcdRW      <= reqRW;
            lcdDataOut <= reqData;
            is_write   <= !reqRW;
            polling    <= 1'b0;
            poll_cnt   <= '0;
          end else begin
            reqReady <= 1'b1;
          end
        end
        ST_SETUP: if (tmr_done) begin
          state <= ST_PULSE;
          lcdE  <= 1'b1;
        end
        // E falls here, so this is the edge that samples read data.
        ST_PULSE: if (tmr_done) begin
          state <= ST_HOLD;
          lcdE  <= 1'b0;
          if (lcdRW) begin
            if (polling) begin
              bf <= lcdDataIn[BF_BIT];
            end else begin
              rspData  <= lcdDataIn;
              rspValid <= 1'b1;
            end
          end
        end
        ST_HOLD: if (tmr_done) begin
          state     <= ST_RECOVER;
          lcdRW     <= 1'b1;
          lcdDataOe <= 1'b0;
        end
        ST_RECOVER: if (tmr_done) begin
          if ((!polling && is_write && (POLL_BUSY != 0)) ||
              (polling && bf && (poll_cnt < PW'(POLL_LIMIT)))) begin
            state     <= ST_SETUP;
            polling   <= 1'b1;
            poll_cnt  <= poll_cnt + 1'b1;
            lcdRS     <= 1'b0;
            lcdRW     <= 1'b1;
            lcdDataOe <= 1'b0;
          end else begin
            if (polling && bf) timeout <= 1'b1;
            state    <= ST_IDLE;
            polling  <= 1'b0;
            reqReady <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_bridge.sv
// Bench for lcd_bus_bridge: unit 0 runs without BF polling, unit 1 polls with a limit of 4.
// Read responses are checked by a queue-based scoreboard; bus timing by per-cycle observation.
// A small panel model answers unit 1's poll reads from a BF script.
module tb_lcd_bus_bridge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] req_valid = '0;
  logic [1:0] req_rs    = '0;
  logic [1:0] req_rw    = '0;
  logic [7:0] req_data [2];
  logic [1:0] req_ready, rsp_valid, busy, timeout, lcd_rs, lcd_rw, lcd_e, lcd_oe;
  logic [7:0] rsp_data [2];
  logic [7:0] lcd_dout [2];
  logic [7:0] din0 = 8'h00;
  logic [7:0] din1 = 8'h00;

  lcd_bus_bridge #(.POLL_BUSY(0)) dut_np (
    .clk(clk), .rst(rst),
    .reqValid(req_valid[0]), .reqReady(req_ready[0]), .reqRS(req_rs[0]), .reqRW(req_rw[0]),
    .reqData(req_data[0]), .rspValid(rsp_valid[0]), .rspData(rsp_data[0]),
    .busy(busy[0]), .timeout(timeout[0]), .lcdRS(lcd_rs[0]), .lcdRW(lcd_rw[0]),
    .lcdE(lcd_e[0]), .lcdDataOut(lcd_dout[0]), .lcdDataOe(lcd_oe[0]), .lcdDataIn(din0)
  );

  lcd_bus_bridge #(.POLL_BUSY(1), .POLL_LIMIT(4)) dut_p (
    .clk(clk), .rst(rst),
    .reqValid(req_valid[1]), .reqReady(req_ready[1]), .reqRS(req_rs[1]), .reqRW(req_rw[1]),
    .reqData(req_data[1]), .rspValid(rsp_valid[1]), .rspData(rsp_data[1]),
    .busy(busy[1]), .timeout(timeout[1]), .lcdRS(lcd_rs[1]), .lcdRW(lcd_rw[1]),
    .lcdE(lcd_e[1]), .lcdDataOut(lcd_dout[1]), .lcdDataOe(lcd_oe[1]), .lcdDataIn(din1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: expected read data is queued at issue time, popped on each rspValid.
  logic [7:0] exp_q[$];
  logic       rsp_prev0 = 1'b0;
  int         rsp_cnt0  = 0;
  always @(negedge clk) begin
    if (rsp_valid[0]) begin
      rsp_cnt0++;
      check("rsp_single_cycle", int'(rsp_prev0), 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected unit0: got data %0h, want no response", rsp_data[0]);
      end else begin
        check("rsp_data", int'(rsp_data[0]), int'(exp_q.pop_front()));
      end
    end
    if (rsp_valid[1]) begin
      total++;
      bad++;
      $display("FAIL rsp_unexpected unit1: got data %0h, want no response", rsp_data[1]);
    end
    rsp_prev0 = rsp_valid[0];
  end

  // Panel model for unit 1 plus E-rise log for unit 0.
  logic pe0 = 1'b0;
  logic pe1 = 1'b0;
  int   rise0[$];
  int   polls = 0;
  logic bf_q[$];
  logic bf_stuck = 1'b0;
  always @(negedge clk) begin
    if (lcd_e[0] && !pe0) rise0.push_back(cyc);
    if (lcd_e[1] && !pe1 && !lcd_rs[1] && lcd_rw[1]) begin
      polls++;
      if (bf_stuck)              din1 = 8'h80;
      else if (bf_q.size() > 0)  din1 = {bf_q.pop_front(), 7'h00};
      else                       din1 = 8'h00;
    end
    pe0 = lcd_e[0];
    pe1 = lcd_e[1];
  end

  typedef struct packed {
    int e_rise; int e_fall; int oe_rise; int oe_fall;
    int rdy_at; int rsp_at; int busy_low; int dout_bad;
  } obs_t;

  task automatic issue(input int u, input logic rs, input logic rw, input logic [7:0] d,
                       input logic hold, output int t_acc);
    int n;
    n = 0;
    @(negedge clk);
    req_valid[u] = 1'b1;
    req_rs[u]    = rs;
    req_rw[u]    = rw;
    req_data[u]  = d;
    while (!req_ready[u] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", int'(req_ready[u]), 1);
    @(negedge clk);
    t_acc = cyc;
    if (!hold) req_valid[u] = 1'b0;
  endtask

  // Observe unit u clock by clock (k = edges since accept) until reqReady returns.
  task automatic watch(input int u, input int t0, input int maxk, input logic [7:0] d,
                       output obs_t o);
    logic pe, poe;
    int   k;
    pe = 1'b0;
    poe = 1'b0;
    o.e_rise = -1; o.e_fall = -1; o.oe_rise = -1; o.oe_fall = -1;
    o.rdy_at = -1; o.rsp_at = -1; o.busy_low = 0; o.dout_bad = 0;
    for (int i = 0; i < maxk; i++) begin
      @(negedge clk);
      k = cyc - t0;
      if (req_ready[u]) begin
        o.rdy_at = k;
        break;
      end
      if (!busy[u]) o.busy_low++;
      if (lcd_e[u] && !pe && o.e_rise < 0) o.e_rise = k;
      if (!lcd_e[u] && pe && o.e_fall < 0) o.e_fall = k;
      if (lcd_oe[u] && !poe && o.oe_rise < 0) o.oe_rise = k;
      if (!lcd_oe[u] && poe && o.oe_fall < 0) o.oe_fall = k;
      if (lcd_oe[u] && lcd_dout[u] != d) o.dout_bad++;
      if (rsp_valid[u] && o.rsp_at < 0) o.rsp_at = k;
      pe  = lcd_e[u];
      poe = lcd_oe[u];
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, want finish by 300000");
    $fatal(1);
  end

  initial begin
    obs_t o;
    int   t0;
    int   acc2;
    req_data[0] = 8'h00;
    req_data[1] = 8'h00;

    // Reset values while rst is held low.
    #12;
    for (int u = 0; u < 2; u++) begin
      check("rst_reqReady", int'(req_ready[u]), 0);
      check("rst_rspValid", int'(rsp_valid[u]), 0);
      check("rst_rspData",  int'(rsp_data[u]), 0);
      check("rst_busy",     int'(busy[u]), 0);
      check("rst_timeout",  int'(timeout[u]), 0);
      check("rst_lcdE",     int'(lcd_e[u]), 0);
      check("rst_lcdRS",    int'(lcd_rs[u]), 0);
      check("rst_lcdRW",    int'(lcd_rw[u]), 1);
      check("rst_lcdData",  int'(lcd_dout[u]), 0);
      check("rst_lcdOe",    int'(lcd_oe[u]), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", int'(req_ready[0]), 1);

    // Write with no polling: RS=1, data 41.
    issue(0, 1'b1, 1'b0, 8'h41, 1'b0, t0);
    watch(0, t0, 60, 8'h41, o);
    check("wr_e_rise",   o.e_rise, 4);
    check("wr_e_fall",   o.e_fall, 16);
    check("wr_oe_rise",  o.oe_rise, 1);
    check("wr_oe_fall",  o.oe_fall, 18);
    check("wr_ready",    o.rdy_at, 26);
    check("wr_busy_low", o.busy_low, 0);
    check("wr_data",     o.dout_bad, 0);
    check("wr_no_rsp",   o.rsp_at, -1);
    check("wr_rs_kept",  int'(lcd_rs[0]), 1);
    check("wr_rw_idle",  int'(lcd_rw[0]), 1);

    // User read: panel returns 5A.
    din0 = 8'h5A;
    exp_q.push_back(8'h5A);
    issue(0, 1'b1, 1'b1, 8'h00, 1'b0, t0);
    watch(0, t0, 60, 8'h00, o);
    check("rd_e_rise",  o.e_rise, 4);
    check("rd_oe_never", o.oe_rise, -1);
    check("rd_rsp_at",  o.rsp_at, 16);
    check("rd_ready",   o.rdy_at, 26);

    // Back-to-back writes with reqValid held high.
    rise0.delete();
    issue(0, 1'b1, 1'b0, 8'h42, 1'b1, t0);
    req_data[0] = 8'h43;
    acc2 = -1;
    for (int i = 0; i < 60; i++) begin
      if (req_ready[0]) begin
        @(negedge clk);
        acc2 = cyc - t0;
        req_valid[0] = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("b2b_second_accept", acc2, 27);
    watch(0, t0 + 27, 60, 8'h43, o);
    check("b2b_e_rise", o.e_rise, 4);
    check("b2b_data",   o.dout_bad, 0);
    check("b2b_ready",  o.rdy_at, 26);
    check("b2b_e_pulses", rise0.size(), 2);
    if (rise0.size() == 2) check("b2b_gap_ge25", int'((rise0[1] - rise0[0]) >= 25), 1);

    // Busy poll: BF reads 1,1,0.
    bf_q.push_back(1'b1);
    bf_q.push_back(1'b1);
    bf_q.push_back(1'b0);
    polls = 0;
    issue(1, 1'b0, 1'b0, 8'h01, 1'b0, t0);
    watch(1, t0, 300, 8'h01, o);
    check("poll_count",    polls, 3);
    check("poll_ready",    o.rdy_at, 101);
    check("poll_busy_low", o.busy_low, 0);
    check("poll_e_rise",   o.e_rise, 4);
    check("poll_wr_data",  o.dout_bad, 0);
    check("poll_timeout",  int'(timeout[1]), 0);
    check("poll_rs_last",  int'(lcd_rs[1]), 0);

    // Poll timeout: BF stuck at 1, limit 4.
    bf_stuck = 1'b1;
    polls = 0;
    issue(1, 1'b0, 1'b0, 8'h38, 1'b0, t0);
    watch(1, t0, 400, 8'h38, o);
    check("to_polls",   polls, 4);
    check("to_ready",   o.rdy_at, 126);
    check("to_timeout", int'(timeout[1]), 1);

    // Timeout is sticky across a later write that polls clean.
    bf_stuck = 1'b0;
    polls = 0;
    issue(1, 1'b0, 1'b0, 8'h0C, 1'b0, t0);
    watch(1, t0, 300, 8'h0C, o);
    check("sticky_polls",   polls, 1);
    check("sticky_ready",   o.rdy_at, 51);
    check("sticky_timeout", int'(timeout[1]), 1);

    // Reset in the middle of PULSE.
    issue(1, 1'b1, 1'b0, 8'h55, 1'b0, t0);
    for (int i = 0; i < 10; i++) begin
      if (lcd_e[1]) break;
      @(negedge clk);
    end
    check("mid_e_seen", int'(lcd_e[1]), 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_e",       int'(lcd_e[1]), 0);
    check("mid_rst_oe",      int'(lcd_oe[1]), 0);
    check("mid_rst_timeout", int'(timeout[1]), 0);
    check("mid_rst_busy",    int'(busy[1]), 0);
    check("mid_rst_ready",   int'(req_ready[1]), 0);
    check("mid_rst_rw",      int'(lcd_rw[1]), 1);
    check("mid_rst_rs",      int'(lcd_rs[1]), 0);
    check("mid_rst_data",    int'(lcd_dout[1]), 0);
    @(negedge clk);
    rst = 1'b1;
    check("mid_rel_ready0", int'(req_ready[1]), 0);
    @(negedge clk);
    check("mid_rel_ready1", int'(req_ready[1]), 1);
    check("mid_rel_e",      int'(lcd_e[1]), 0);

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("rsp_count",   rsp_cnt0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
